// File: rtl/mips_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl_if
// Description : Bus between the multi-cycle MIPS controller and its datapath.
//               Carries the IR contents, the ALU zero flag, and the memory
//               req/rdy handshake. It also carries every control, debug and
//               performance output.
//               modport slave  : controller side (mips_mc_ctrl)
//               modport master : datapath / memory side
// Ports       : instruction[31:0], zero, mem_rdy         (datapath -> ctrl)
//               mem_req, PCWr, IRWr, RegWr, MemWr          (ctrl -> datapath)
//               RegDst, ALUSrc, MemtoReg, j_sel, jal_sel,
//               jr_sel, lb_sel, ExtOp[1:0], nPC_sel[1:0],
//               ALUctr[ALUCTR_W-1:0]                       (ctrl -> datapath)
//               state[2:0], err, cyc_cnt[31:0], instret[31:0] (debug/perf)
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_mc_ctrl_if #(
  parameter int ALUCTR_W = 4
);
  logic [31:0]         instruction;
  logic                zero;
  logic                mem_rdy;
  logic                mem_req;
  logic                PCWr;
  logic                IRWr;
  logic                RegWr;
  logic                MemWr;
  logic                RegDst;
  logic                ALUSrc;
  logic                MemtoReg;
  logic                j_sel;
  logic                jal_sel;
  logic                jr_sel;
  logic                lb_sel;
  logic [1:0]          ExtOp;
  logic [1:0]          nPC_sel;
  logic [ALUCTR_W-1:0] ALUctr;
  logic [2:0]          state;
  logic                err;
  logic [31:0]         cyc_cnt;
  logic [31:0]         instret;

  modport slave (
    input  instruction, zero, mem_rdy,
    output mem_req, PCWr, IRWr, RegWr, MemWr,
    output RegDst, ALUSrc, MemtoReg, j_sel, jal_sel, jr_sel, lb_sel,
    output ExtOp, nPC_sel, ALUctr, state, err, cyc_cnt, instret
  );

  modport master (
    output instruction, zero, mem_rdy,
    input  mem_req, PCWr, IRWr, RegWr, MemWr,
    input  RegDst, ALUSrc, MemtoReg, j_sel, jal_sel, jr_sel, lb_sel,
    input  ExtOp, nPC_sel, ALUctr, state, err, cyc_cnt, instret
  );
endinterface
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Multi-cycle MIPS control unit. A Moore FSM steps each
//               instruction through IF/ID/EXE/MEM/WB. Memory accesses use a
//               req/rdy handshake, so memory may insert wait states, and a
//               timeout guards each access. Write enables are qualified by
//               state. Datapath selects are decoded from IR in every
//               non-reset state.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               bus (slave)  - mips_mc_ctrl_if: instruction/zero/mem_rdy in;
//                              write enables, selects, state, err, cyc_cnt,
//                              instret out
// Parameters  : ALUCTR_W     - ALUctr width
//               MEM_TIMEOUT  - wait cycles before a memory error (0 = never)
//               TO_W         - timeout counter width (must hold MEM_TIMEOUT)
// Config      : MC_CTRL_PERF_EN - when defined, cyc_cnt/instret count;
//                                 otherwise both are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
  parameter int ALUCTR_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic          clk,
  input  logic          rst,
  mips_mc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_RST = 3'd0,
    S_IF  = 3'd1,
    S_ID  = 3'd2,
    S_EXE = 3'd3,
    S_MEM = 3'd4,
    S_WB  = 3'd5,
    S_ERR = 3'd7
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_LB    = 6'b100000;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;
  localparam logic [5:0] c_FN_JR    = 6'b001000;

  // The last count value before the timeout fires. Hitting it while still
  // waiting makes the access's MEM_TIMEOUT-th wait cycle the final one.
  localparam logic [TO_W-1:0] c_TO_LAST =
    TO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_addu, w_subu, w_jr, w_ori, w_lui;
  logic       w_lw, w_lb, w_sw, w_beq, w_j, w_jal;
  logic       w_unused;

  assign w_op   = bus.instruction[31:26];
  assign w_fn   = bus.instruction[5:0];
  assign w_addu = (w_op == c_OP_RTYPE) && (w_fn == c_FN_ADDU);
  assign w_subu = (w_op == c_OP_RTYPE) && (w_fn == c_FN_SUBU);
  assign w_jr   = (w_op == c_OP_RTYPE) && (w_fn == c_FN_JR);
  assign w_ori  = (w_op == c_OP_ORI);
  assign w_lui  = (w_op == c_OP_LUI);
  assign w_lw   = (w_op == c_OP_LW);
  assign w_lb   = (w_op == c_OP_LB);
  assign w_sw   = (w_op == c_OP_SW);
  assign w_beq  = (w_op == c_OP_BEQ);
  assign w_j    = (w_op == c_OP_J);
  assign w_jal  = (w_op == c_OP_JAL);
  // Register and immediate fields feed the datapath, not this block.
  assign w_unused = &{1'b0, bus.instruction[25:6]};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_hit;
  logic            w_mem_req, w_pcwr, w_irwr, w_regwr, w_memwr;

  assign w_to_hit = (MEM_TIMEOUT != 0) && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and write enables
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_pcwr    = 1'b0;
    w_irwr    = 1'b0;
    w_regwr   = 1'b0;
    w_memwr   = 1'b0;
    case (r_state)
      S_RST: w_next = S_IF;
      S_IF: begin
        w_mem_req = 1'b1;
        if (bus.mem_rdy) begin
          w_irwr = 1'b1;
          w_pcwr = 1'b1;
          w_next = S_ID;
        end else if (w_to_hit) begin
          w_next = S_ERR;
        end
      end
      S_ID: begin
        if (w_addu || w_subu || w_ori || w_lui || w_lw || w_lb || w_sw || w_beq) begin
          w_next = S_EXE;
        end else if (w_j || w_jr) begin
          w_pcwr = 1'b1;
          w_next = S_IF;
        end else if (w_jal) begin
          // PC is redirected now; the link register is written in WB.
          w_pcwr = 1'b1;
          w_next = S_WB;
        end else begin
          w_next = S_ERR;
        end
      end
      S_EXE: begin
        if (w_lw || w_lb || w_sw) begin
          w_next = S_MEM;
        end else if (w_beq) begin
          w_pcwr = bus.zero;
          w_next = S_IF;
        end else if (w_addu || w_subu || w_ori || w_lui) begin
          w_next = S_WB;
        end else begin
          w_next = S_ERR;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        // Store data is held valid for the whole access, wait states included.
        w_memwr   = w_sw;
        if (bus.mem_rdy) begin
          w_next = w_sw ? S_IF : S_WB;
        end else if (w_to_hit) begin
          w_next = S_ERR;
        end
      end
      S_WB: begin
        w_regwr = 1'b1;
        w_next  = S_IF;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory wait timeout: cleared on every state change, so each IF or MEM
  // access starts from zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_next != r_state) begin
      r_to_cnt <= '0;
    end else if (w_mem_req && !bus.mem_rdy) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath selects, decoded from IR in every non-reset state
  // --------------------------------------------------------------------------
  logic                w_regdst, w_alusrc, w_memtoreg;
  logic                w_jsel, w_jalsel, w_jrsel, w_lbsel;
  logic [1:0]          w_extop, w_npcsel;
  logic [ALUCTR_W-1:0] w_aluctr;

  always_comb begin
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_jsel     = 1'b0;
    w_jalsel   = 1'b0;
    w_jrsel    = 1'b0;
    w_lbsel    = 1'b0;
    w_extop    = 2'b00;
    w_npcsel   = 2'b00;
    w_aluctr   = '0;
    if (r_state != S_RST) begin
      w_regdst   = w_addu || w_subu;
      w_alusrc   = w_ori || w_lui || w_lw || w_lb || w_sw;
      w_memtoreg = w_lw || w_lb;
      w_jsel     = w_j || w_jal;
      w_jalsel   = w_jal;
      w_jrsel    = w_jr;
      w_lbsel    = w_lb;
      if (w_lui) begin
        w_extop = 2'b10;
      end else if (w_lw || w_lb || w_sw || w_beq) begin
        w_extop = 2'b01;
      end
      // IF always advances to PC+4; IR still holds the previous instruction.
      if (w_beq && (r_state != S_IF)) begin
        w_npcsel = 2'b01;
      end
      if (w_subu || w_beq) begin
        w_aluctr = ALUCTR_W'(1);
      end else if (w_ori) begin
        w_aluctr = ALUCTR_W'(2);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instret;
  logic        w_retire;

  assign w_retire = (w_next == S_IF) &&
                    ((r_state == S_ID) || (r_state == S_EXE) ||
                     (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_instret <= '0;
    end else begin
      if ((r_state != S_RST) && (r_state != S_ERR)) begin
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign bus.cyc_cnt = r_cyc_cnt;
  assign bus.instret = r_instret;
`else
  assign bus.cyc_cnt = '0;
  assign bus.instret = '0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.mem_req  = w_mem_req;
  assign bus.PCWr     = w_pcwr;
  assign bus.IRWr     = w_irwr;
  assign bus.RegWr    = w_regwr;
  assign bus.MemWr    = w_memwr;
  assign bus.RegDst   = w_regdst;
  assign bus.ALUSrc   = w_alusrc;
  assign bus.MemtoReg = w_memtoreg;
  assign bus.j_sel    = w_jsel;
  assign bus.jal_sel  = w_jalsel;
  assign bus.jr_sel   = w_jrsel;
  assign bus.lb_sel   = w_lbsel;
  assign bus.ExtOp    = w_extop;
  assign bus.nPC_sel  = w_npcsel;
  assign bus.ALUctr   = w_aluctr;
  assign bus.state    = r_state;
  // ERR is absorbing until reset, so this flag is sticky.
  assign bus.err      = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mc_ctrl
// Description : Self-checking bench for mips_mc_ctrl. A per-cycle vector
//               table covers the instruction flows. Hand-written sequences
//               cover decode selects, timeout, illegal opcode, async reset and
//               the performance counters. Honours MC_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;
  localparam int ALUCTR_W    = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int TO_W        = 4;

  localparam logic [2:0] S_RST = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EXE = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd7;

  localparam logic [31:0] I_ADDU = 32'h0022_1821, I_SUBU = 32'h0022_1823;
  localparam logic [31:0] I_ORI  = 32'h3422_0005, I_LUI  = 32'h3C02_0005;
  localparam logic [31:0] I_LW   = 32'h8C22_0004, I_LB   = 32'h8022_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0004, I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_J    = 32'h0800_0010, I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008, I_ILL  = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_mc_ctrl_if #(.ALUCTR_W(ALUCTR_W)) bus ();

  mips_mc_ctrl #(
    .ALUCTR_W   (ALUCTR_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        z;
    logic        rdy;
    logic [2:0]  st;
    logic        req;
    logic [3:0]  we;   // {PCWr, IRWr, RegWr, MemWr}
  } cyc_t;

  typedef struct {
    string      nm;
    logic [2:0] st;
    logic       req;
    logic [3:0] we;
    logic [1:0] npc;
    logic       ck_npc;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic [6:0]  sel;  // {RegDst, ALUSrc, MemtoReg, j_sel, jal_sel, jr_sel, lb_sel}
    logic [1:0]  ext;
    logic [3:0]  alu;
  } dec_t;

  cyc_t vec[$];
  exp_t sb[$];
  dec_t dec[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic cyc_t mk(input string nm, input logic [31:0] i, input logic z,
                              input logic r, input logic [2:0] s, input logic q,
                              input logic [3:0] w);
    cyc_t c;
    c.nm = nm; c.ins = i; c.z = z; c.rdy = r; c.st = s; c.req = q; c.we = w;
    return c;
  endfunction

  function automatic dec_t md(input string nm, input logic [31:0] i, input logic [6:0] s,
                              input logic [1:0] e, input logic [3:0] a);
    dec_t d;
    d.nm = nm; d.ins = i; d.sel = s; d.ext = e; d.alu = a;
    return d;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then compare it.
  task automatic step(input cyc_t c);
    exp_t e;
    @(negedge clk);
    bus.instruction = c.ins;
    bus.zero        = c.z;
    bus.mem_rdy     = c.rdy;
    e.nm     = c.nm;
    e.st     = c.st;
    e.req    = c.req;
    e.we     = c.we;
    e.ck_npc = (c.st == S_IF) || (c.st == S_EXE);
    e.npc    = ((c.st == S_EXE) && (c.ins[31:26] == 6'b000100)) ? 2'b01 : 2'b00;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({e.nm, " state"}, 64'(bus.state), 64'(e.st));
    check({e.nm, " req/we"},
          64'({bus.mem_req, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr}),
          64'({e.req, e.we}));
    if (e.ck_npc) check({e.nm, " nPC_sel"}, 64'(bus.nPC_sel), 64'(e.npc));
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.instruction = 32'h0;
    bus.zero        = 1'b0;
    bus.mem_rdy     = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs",
          64'({bus.mem_req, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.RegDst,
               bus.ALUSrc, bus.MemtoReg, bus.j_sel, bus.jal_sel, bus.jr_sel, bus.lb_sel,
               bus.ExtOp, bus.nPC_sel, bus.ALUctr, bus.state, bus.err}), 64'h0);
    check("reset counters", {bus.cyc_cnt, bus.instret}, 64'h0);
    rst = 1'b0;
    #1;
    check("reset release state", 64'(bus.state), 64'(S_RST));
  endtask

  initial begin
    int n;
    logic [63:0] exp_cyc, exp_ret;

    // ---- per-cycle vectors, starting in the first cycle after RST ----
    vec.push_back(mk("addu IF",  I_ADDU, 0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("addu ID",  I_ADDU, 0, 0, S_ID,  0, 4'b0000));
    vec.push_back(mk("addu EXE", I_ADDU, 0, 1, S_EXE, 0, 4'b0000));
    vec.push_back(mk("addu WB",  I_ADDU, 0, 1, S_WB,  0, 4'b0010));
    vec.push_back(mk("ori IF",   I_ORI,  0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("ori ID",   I_ORI,  0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("ori EXE",  I_ORI,  0, 0, S_EXE, 0, 4'b0000));
    vec.push_back(mk("ori WB",   I_ORI,  0, 0, S_WB,  0, 4'b0010));
    vec.push_back(mk("lw IF",    I_LW,   0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("lw ID",    I_LW,   0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("lw EXE",   I_LW,   0, 1, S_EXE, 0, 4'b0000));
    vec.push_back(mk("lw MEM w1", I_LW,  0, 0, S_MEM, 1, 4'b0000));
    vec.push_back(mk("lw MEM w2", I_LW,  0, 0, S_MEM, 1, 4'b0000));
    vec.push_back(mk("lw MEM w3", I_LW,  0, 0, S_MEM, 1, 4'b0000));
    vec.push_back(mk("lw MEM rdy", I_LW, 0, 1, S_MEM, 1, 4'b0000));
    vec.push_back(mk("lw WB",    I_LW,   0, 1, S_WB,  0, 4'b0010));
    vec.push_back(mk("lb IF",    I_LB,   0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("lb ID",    I_LB,   0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("lb EXE",   I_LB,   0, 1, S_EXE, 0, 4'b0000));
    vec.push_back(mk("lb MEM",   I_LB,   0, 1, S_MEM, 1, 4'b0000));
    vec.push_back(mk("lb WB",    I_LB,   0, 1, S_WB,  0, 4'b0010));
    vec.push_back(mk("sw IF",    I_SW,   0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("sw ID",    I_SW,   0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("sw EXE",   I_SW,   0, 1, S_EXE, 0, 4'b0000));
    vec.push_back(mk("sw MEM w1", I_SW,  0, 0, S_MEM, 1, 4'b0001));
    vec.push_back(mk("sw MEM rdy", I_SW, 0, 1, S_MEM, 1, 4'b0001));
    vec.push_back(mk("beq1 IF",  I_BEQ,  0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("beq1 ID",  I_BEQ,  0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("beq1 EXE", I_BEQ,  1, 1, S_EXE, 0, 4'b1000));
    vec.push_back(mk("beq0 IF",  I_BEQ,  0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("beq0 ID",  I_BEQ,  0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("beq0 EXE", I_BEQ,  0, 1, S_EXE, 0, 4'b0000));
    vec.push_back(mk("j IF wait", I_J,   0, 0, S_IF,  1, 4'b0000));
    vec.push_back(mk("j IF rdy", I_J,    0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("j ID",     I_J,    0, 0, S_ID,  0, 4'b1000));
    vec.push_back(mk("jal IF",   I_JAL,  0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("jal ID",   I_JAL,  0, 1, S_ID,  0, 4'b1000));
    vec.push_back(mk("jal WB",   I_JAL,  0, 1, S_WB,  0, 4'b0010));
    vec.push_back(mk("jr IF",    I_JR,   0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("jr ID",    I_JR,   0, 1, S_ID,  0, 4'b1000));
    vec.push_back(mk("subu IF",  I_SUBU, 0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("subu ID",  I_SUBU, 0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("subu EXE", I_SUBU, 0, 1, S_EXE, 0, 4'b0000));
    vec.push_back(mk("subu WB",  I_SUBU, 0, 1, S_WB,  0, 4'b0010));
    vec.push_back(mk("lui IF",   I_LUI,  0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("lui ID",   I_LUI,  0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("lui EXE",  I_LUI,  0, 1, S_EXE, 0, 4'b0000));
    vec.push_back(mk("lui WB",   I_LUI,  0, 1, S_WB,  0, 4'b0010));
    vec.push_back(mk("ill IF",   I_ILL,  0, 1, S_IF,  1, 4'b1100));
    vec.push_back(mk("ill ID",   I_ILL,  0, 1, S_ID,  0, 4'b0000));
    vec.push_back(mk("ill ERR",  I_ILL,  0, 1, S_ERR, 0, 4'b0000));
    vec.push_back(mk("ill ERR2", I_J,    0, 1, S_ERR, 0, 4'b0000));

    // ---- decode table: {RegDst,ALUSrc,MemtoReg,j,jal,jr,lb}, ExtOp, ALUctr ----
    dec.push_back(md("dec addu", I_ADDU, 7'b1000000, 2'b00, 4'b0000));
    dec.push_back(md("dec subu", I_SUBU, 7'b1000000, 2'b00, 4'b0001));
    dec.push_back(md("dec ori",  I_ORI,  7'b0100000, 2'b00, 4'b0010));
    dec.push_back(md("dec lui",  I_LUI,  7'b0100000, 2'b10, 4'b0000));
    dec.push_back(md("dec lw",   I_LW,   7'b0110000, 2'b01, 4'b0000));
    dec.push_back(md("dec lb",   I_LB,   7'b0110001, 2'b01, 4'b0000));
    dec.push_back(md("dec sw",   I_SW,   7'b0100000, 2'b01, 4'b0000));
    dec.push_back(md("dec beq",  I_BEQ,  7'b0000000, 2'b01, 4'b0001));
    dec.push_back(md("dec j",    I_J,    7'b0001000, 2'b00, 4'b0000));
    dec.push_back(md("dec jal",  I_JAL,  7'b0001100, 2'b00, 4'b0000));
    dec.push_back(md("dec jr",   I_JR,   7'b0000010, 2'b00, 4'b0000));

    // ---- main vector run ----
    do_reset();
    for (int i = 0; i < vec.size(); i++) step(vec[i]);
    check("ill err flag", 64'(bus.err), 64'h1);

    // ---- selects, observed while IF waits on memory ----
    do_reset();
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < dec.size(); i++) begin
      @(negedge clk);
      bus.instruction = dec[i].ins;
      #1;
      check({dec[i].nm, " sel"},
            64'({bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.j_sel, bus.jal_sel,
                 bus.jr_sel, bus.lb_sel, bus.ExtOp, bus.ALUctr}),
            64'({dec[i].sel, dec[i].ext, dec[i].alu}));
    end

    // ---- fetch timeout ----
    do_reset();
    bus.mem_rdy = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (bus.state != S_IF) break;
      n++;
    end
    check("timeout IF cycles", 64'(n), 64'd15);
    check("timeout err", 64'({bus.state, bus.err}), 64'({S_ERR, 1'b1}));
    for (int k = 0; k < 4; k++) begin
      step(mk("ERR hold", I_J, 1, 1, S_ERR, 0, 4'b0000));
      check("ERR hold err", 64'(bus.err), 64'h1);
    end

    // ---- asynchronous reset mid-fetch ----
    do_reset();
    step(mk("arst IF", I_LW, 0, 0, S_IF, 1, 4'b0000));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst drop",
          64'({bus.state, bus.mem_req, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr}), 64'h0);

    // ---- ten zero-wait jumps and the performance counters ----
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(mk("perf j IF", I_J, 0, 1, S_IF, 1, 4'b1100));
      step(mk("perf j ID", I_J, 0, 1, S_ID, 0, 4'b1000));
    end
    step(mk("perf j IF", I_J, 0, 1, S_IF, 1, 4'b1100));
    @(negedge clk);
    #1;
`ifdef MC_CTRL_PERF_EN
    exp_cyc = 64'd21;
    exp_ret = 64'd10;
`else
    exp_cyc = 64'd0;
    exp_ret = 64'd0;
`endif
    check("perf cyc_cnt", 64'(bus.cyc_cnt), exp_cyc);
    check("perf instret", 64'(bus.instret), exp_ret);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
